// File: rtl/atconv_param_engine.sv
// Parameterised atrous-convolution layer engine: 3x3 dilated kernel with bias,
// replicate padding, ReLU/saturation into layer 0, optional 2x2 ceil max-pool into layer 1.
module atconv_param_engine #(
   parameter int IMG_W = 64,
   parameter int IMG_H = 64,
   parameter int DIL   = 2,
   parameter int DW    = 13,
   parameter int FRAC  = 4,
   parameter int AW    = $clog2(IMG_W*IMG_H)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          ready,
   input  logic [DW-1:0] bias,
   input  logic          pool_en,
   output logic          busy,
   output logic          done,
   output logic [AW-1:0] iaddr,
   input  logic [DW-1:0] idata,
   output logic          cwr,
   output logic [AW-1:0] caddr_wr,
   output logic [DW-1:0] cdata_wr,
   output logic          crd,
   output logic [AW-1:0] caddr_rd,
   input  logic [DW-1:0] cdata_rd,
   output logic          csel
);

   localparam int CW   = $clog2(IMG_W);
   localparam int RW   = $clog2(IMG_H);
   localparam int OW   = AW - 2;
   localparam int ACCW = DW + 4;
   localparam logic [DW-1:0] MAXV   = {1'b0, {(DW-1){1'b1}}};
   localparam logic [DW-1:0] MAXINT = {1'b0, {(DW-1-FRAC){1'b1}}, {FRAC{1'b0}}};

   typedef enum logic [2:0] {S_IDLE, S_CONV, S_L0WR, S_POOL, S_L1WR, S_FIN} state_t;

   state_t state, state_nx;

   logic [AW-1:0]          pix;
   logic [1:0]             ty, tx;
   logic [2:0]             step;
   logic [OW-1:0]          opix;
   logic signed [ACCW-1:0] acc, acc_nx, ix, wtap;
   logic signed [DW-1:0]   mx, bias_q;
   logic                   pool_q;
   logic [AW-1:0]          tap_addr;
   logic signed [ACCW:0]   y;
   logic [DW-1:0]          l0_data, l1_data;
   logic [DW-FRAC:0]       ip;
   int                     rr, cc;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= S_IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         S_IDLE: if (ready) state_nx = S_CONV;
         S_CONV: if (ty == 2'd2 && tx == 2'd2) state_nx = S_L0WR;
         S_L0WR: begin
            if (pix == '1) state_nx = pool_q ? S_POOL : S_FIN;
            else           state_nx = S_CONV;
         end
         S_POOL: if (step == 3'd4) state_nx = S_L1WR;
         S_L1WR: state_nx = (opix == '1) ? S_FIN : S_POOL;
         S_FIN:  state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   // Tap coordinates clamped independently per axis (replicate padding)
   always_comb begin
      rr = int'(pix[AW-1:CW]) + (int'(ty) - 1) * DIL;
      cc = int'(pix[CW-1:0])  + (int'(tx) - 1) * DIL;
      if (rr < 0) rr = 0;
      else if (rr > IMG_H-1) rr = IMG_H-1;
      if (cc < 0) cc = 0;
      else if (cc > IMG_W-1) cc = IMG_W-1;
      tap_addr = {RW'(rr), CW'(cc)};
   end

   always_comb begin
      ix = {{4{idata[DW-1]}}, idata};
      if (ty == 2'd1 && tx == 2'd1) wtap = ix;
      else if (ty == 2'd1)          wtap = -(ix >>> 2);
      else if (tx == 2'd1)          wtap = -(ix >>> 3);
      else                          wtap = -(ix >>> 4);
      acc_nx = ((ty == 2'd0 && tx == 2'd0) ? '0 : acc) + wtap;
   end

   always_comb begin
      y = {acc[ACCW-1], acc} + {{(ACCW+1-DW){bias_q[DW-1]}}, bias_q};
      if (y[ACCW])                 l0_data = '0;
      else if (|y[ACCW-1:DW-1])    l0_data = MAXV;
      else                         l0_data = y[DW-1:0];
   end

   // Integer ceiling of the pooled max; overflow lands on the largest integer
   always_comb begin
      ip = {1'b0, mx[DW-1:FRAC]} + {{(DW-FRAC){1'b0}}, |mx[FRAC-1:0]};
      if (ip[DW-FRAC] || ip[DW-FRAC-1]) l1_data = MAXINT;
      else                              l1_data = {ip[DW-FRAC-1:0], {FRAC{1'b0}}};
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pix    <= '0;
         ty     <= '0;
         tx     <= '0;
         step   <= '0;
         opix   <= '0;
         acc    <= '0;
         mx     <= '0;
         bias_q <= '0;
         pool_q <= 1'b0;
      end else begin
         unique case (state)
            S_IDLE: if (ready) begin
               bias_q <= bias;
               pool_q <= pool_en;
               pix    <= '0;
               ty     <= '0;
               tx     <= '0;
               step   <= '0;
               opix   <= '0;
            end
            S_CONV: begin
               acc <= acc_nx;
               if (tx == 2'd2) begin
                  tx <= '0;
                  ty <= (ty == 2'd2) ? 2'd0 : ty + 2'd1;
               end else begin
                  tx <= tx + 2'd1;
               end
            end
            S_L0WR: pix <= pix + 1'b1;
            S_POOL: begin
               step <= (step == 3'd4) ? 3'd0 : step + 3'd1;
               if (step == 3'd0)                mx <= '0;
               else if ($signed(cdata_rd) > mx) mx <= cdata_rd;
            end
            S_L1WR: opix <= opix + 1'b1;
            default: ;
         endcase
      end
   end

   always_comb begin
      busy     = (state == S_CONV) || (state == S_L0WR) || (state == S_POOL) || (state == S_L1WR);
      done     = (state == S_FIN);
      iaddr    = (state == S_CONV) ? tap_addr : '0;
      cwr      = (state == S_L0WR) || (state == S_L1WR);
      csel     = (state == S_L1WR);
      caddr_wr = '0;
      cdata_wr = '0;
      if (state == S_L0WR) begin
         caddr_wr = pix;
         cdata_wr = l0_data;
      end else if (state == S_L1WR) begin
         caddr_wr = {2'b00, opix};
         cdata_wr = l1_data;
      end
      crd      = (state == S_POOL) && (step != 3'd4);
      caddr_rd = crd ? {opix[OW-1:CW-1], step[1], opix[CW-2:0], step[0]} : '0;
   end

endmodule

// File: tb/tb_atconv_param_engine.sv
// Directed scoreboard bench for atconv_param_engine on a 16x16 image with dilation 2.
module tb_atconv_param_engine;

   localparam int IMG_W = 16;
   localparam int IMG_H = 16;
   localparam int DIL   = 2;
   localparam int DW    = 13;
   localparam int FRAC  = 4;
   localparam int AW    = 8;
   localparam int N     = IMG_W * IMG_H;
   localparam int NP    = N / 4;
   localparam int CYC_POOL   = 10*N + 6*N/4 + 1;
   localparam int CYC_NOPOOL = 10*N + 1;

   logic          clk = 1'b0;
   logic          reset, ready, pool_en;
   logic [DW-1:0] bias, idata, cdata_wr, cdata_rd;
   logic          busy, done, cwr, crd, csel;
   logic [AW-1:0] iaddr, caddr_wr, caddr_rd;

   logic [DW-1:0] img  [N];
   logic [DW-1:0] mem0 [N];
   logic [DW-1:0] mem1 [NP];

   typedef struct packed {
      logic          sel;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } wr_t;
   wr_t sb[$];

   int total = 0;
   int bad   = 0;

   atconv_param_engine #(.IMG_W(IMG_W), .IMG_H(IMG_H), .DIL(DIL), .DW(DW), .FRAC(FRAC), .AW(AW)) dut (
      .clk(clk), .reset(reset), .ready(ready), .bias(bias), .pool_en(pool_en),
      .busy(busy), .done(done), .iaddr(iaddr), .idata(idata),
      .cwr(cwr), .caddr_wr(caddr_wr), .cdata_wr(cdata_wr),
      .crd(crd), .caddr_rd(caddr_rd), .cdata_rd(cdata_rd), .csel(csel)
   );

   always #5 clk = ~clk;

   assign idata = img[iaddr];

   always @(posedge clk) begin
      if (cwr) begin
         if (csel) mem1[caddr_wr[AW-3:0]] <= cdata_wr;
         else      mem0[caddr_wr]         <= cdata_wr;
      end
      if (crd) cdata_rd <= csel ? mem1[caddr_rd[AW-3:0]] : mem0[caddr_rd];
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int clampi(input int v, input int lo, input int hi);
      return (v < lo) ? lo : (v > hi) ? hi : v;
   endfunction

   task automatic set_img(input logic [DW-1:0] v);
      for (int k = 0; k < N; k++) img[k] = v;
   endtask

   // Reference model: expected layer writes in issue order
   task automatic build_expect(input int bias_v, input bit pen);
      int  l0 [N];
      int  acc, v, yv, m, smax;
      wr_t e;
      smax = 2**(DW-1) - 1;
      for (int r = 0; r < IMG_H; r++) begin
         for (int c = 0; c < IMG_W; c++) begin
            acc = 0;
            for (int dy = -1; dy <= 1; dy++) begin
               for (int dx = -1; dx <= 1; dx++) begin
                  v = int'($signed(img[clampi(r+dy*DIL, 0, IMG_H-1)*IMG_W + clampi(c+dx*DIL, 0, IMG_W-1)]));
                  if (dy == 0 && dx == 0) acc += v;
                  else if (dy == 0)       acc -= v >>> 2;
                  else if (dx == 0)       acc -= v >>> 3;
                  else                    acc -= v >>> 4;
               end
            end
            yv = acc + bias_v;
            if (yv < 0)    yv = 0;
            if (yv > smax) yv = smax;
            l0[r*IMG_W + c] = yv;
            e.sel = 1'b0; e.addr = AW'(r*IMG_W + c); e.data = DW'(yv);
            sb.push_back(e);
         end
      end
      if (pen) begin
         for (int o = 0; o < NP; o++) begin
            int i, j;
            i = o / (IMG_W/2);
            j = o % (IMG_W/2);
            m = 0;
            for (int q = 0; q < 4; q++) begin
               v = l0[(2*i + q/2)*IMG_W + 2*j + q%2];
               if (v > m) m = v;
            end
            if (m % (2**FRAC) != 0) m = (m / (2**FRAC) + 1) * (2**FRAC);
            if (m > smax) m = smax - (2**FRAC - 1);
            e.sel = 1'b1; e.addr = AW'(o); e.data = DW'(m);
            sb.push_back(e);
         end
      end
   endtask

   task automatic run_job(input logic [DW-1:0] b, input bit pen, input int extra_ready_at,
                          output int cycles, output int l0w, output int l1w,
                          output int rdn, output int rdsel, output int first_addr);
      int  dones;
      wr_t w;
      cycles = 0; l0w = 0; l1w = 0; rdn = 0; rdsel = 0; first_addr = -1; dones = 0;
      build_expect(int'($signed(b)), pen);
      @(negedge clk);
      bias = b; pool_en = pen; ready = 1'b1;
      @(negedge clk);
      ready = 1'b0; bias = 13'h1ABC; pool_en = ~pen;
      for (int n = 0; n < CYC_POOL + 50; n++) begin
         if (busy || done) cycles++;
         if (cwr) begin
            if (first_addr < 0) first_addr = int'(caddr_wr);
            if (csel) l1w++; else l0w++;
            if (sb.size() == 0) check("write_unexpected", {csel, caddr_wr, cdata_wr}, '0);
            else begin
               w = sb.pop_front();
               check("write", {csel, caddr_wr, cdata_wr}, w);
            end
         end
         if (crd) begin
            rdn++;
            if (csel) rdsel++;
         end
         if (done) begin
            dones++;
            break;
         end
         ready = (n == extra_ready_at);
         @(negedge clk);
      end
      ready = 1'b0;
      check("done_seen", dones, 1);
      check("sb_drained", sb.size(), 0);
      sb.delete();
      @(negedge clk);
      check("done_one_cycle", {busy, done}, 2'b00);
   endtask

   initial begin
      int cyc, l0w, l1w, rdn, rdsel, fa;
      bit found;
      reset = 1'b0; ready = 1'b0; bias = '0; pool_en = 1'b0;
      set_img('0);
      repeat (3) @(negedge clk);
      check("reset_outputs", {busy, done, cwr, crd, csel, iaddr, caddr_wr, cdata_wr, caddr_rd}, '0);
      reset = 1'b1;
      @(negedge clk);

      // constant image, pool on
      set_img(13'h0010);
      run_job(13'h000C, 1'b1, -1, cyc, l0w, l1w, rdn, rdsel, fa);
      check("s1_cycles", cyc, CYC_POOL);
      check("s1_l0_words", l0w, N);
      check("s1_l1_words", l1w, NP);
      check("s1_reads", rdn, 4*NP);
      check("s1_read_bank", rdsel, 0);
      check("s1_l0_val", mem0[37], 13'h000C);
      check("s1_l1_val", mem1[20], 13'h0010);

      // impulse in the interior
      set_img('0);
      img[10*IMG_W + 10] = 13'h0100;
      run_job(13'h0000, 1'b1, -1, cyc, l0w, l1w, rdn, rdsel, fa);
      check("s2_centre", mem0[10*IMG_W + 10], 13'h0100);
      check("s2_left",   mem0[10*IMG_W + 8],  13'h0000);
      check("s2_right",  mem0[10*IMG_W + 12], 13'h0000);
      check("s2_up",     mem0[8*IMG_W + 10],  13'h0000);
      check("s2_corner", mem0[8*IMG_W + 8],   13'h0000);
      check("s2_pool",   mem1[5*(IMG_W/2) + 5], 13'h0100);

      // impulse at the corner exercises clamping
      set_img('0);
      img[0] = 13'h0100;
      run_job(13'h0000, 1'b1, -1, cyc, l0w, l1w, rdn, rdsel, fa);
      check("s3_border", mem0[0], 13'h0090);

      // saturation in both layers
      set_img('0);
      img[12*IMG_W + 12] = 13'h0FFF;
      run_job(13'h0FFF, 1'b1, -1, cyc, l0w, l1w, rdn, rdsel, fa);
      check("s4_l0_sat", mem0[12*IMG_W + 12], 13'h0FFF);
      check("s4_l1_sat", mem1[6*(IMG_W/2) + 6], 13'h0FF0);

      // pool disabled
      set_img(13'h0010);
      run_job(13'h000C, 1'b0, -1, cyc, l0w, l1w, rdn, rdsel, fa);
      check("s5_cycles", cyc, CYC_NOPOOL);
      check("s5_l0_words", l0w, N);
      check("s5_l1_words", l1w, 0);
      check("s5_reads", rdn, 0);

      // abort mid-conv via reset
      @(negedge clk);
      bias = 13'h0003; pool_en = 1'b1; ready = 1'b1;
      @(negedge clk);
      ready = 1'b0;
      found = 1'b0;
      for (int n = 0; n < 2000; n++) begin
         if (cwr && caddr_wr == AW'(99)) begin
            found = 1'b1;
            break;
         end
         @(negedge clk);
      end
      check("s6_reach_px100", found, 1'b1);
      @(negedge clk);
      #1 reset = 1'b0;
      #1 check("s6_abort_outputs", {busy, cwr, crd, done, csel, iaddr, caddr_wr, caddr_rd}, '0);
      for (int n = 0; n < 3; n++) begin
         @(negedge clk);
         check("s6_held_quiet", {busy, cwr, crd, done}, 4'b0);
      end
      reset = 1'b1;
      @(negedge clk);
      set_img(13'h0010);
      img[3*IMG_W + 5] = 13'h0400;
      run_job(13'h0005, 1'b1, 40, cyc, l0w, l1w, rdn, rdsel, fa);
      check("s6_first_addr", fa, 0);
      check("s6_cycles", cyc, CYC_POOL);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
